// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks E/M/W destination registers, raises the D-stage stall and drives the
// ALU operand forwarding selects. Define HAZARD_MDU_EN to add the mult/div interlock ports.
module hazard_ctrl #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] D_rs,
  input  logic [AW-1:0] D_rt,
  input  logic [1:0]    D_tuse_rs,
  input  logic [1:0]    D_tuse_rt,
  input  logic [AW-1:0] D_dst,
  input  logic [1:0]    D_tnew,
  input  logic          E_clr,
`ifdef HAZARD_MDU_EN
  input  logic          D_is_md,
  input  logic          md_start,
  input  logic          md_busy,
`endif
  output logic          stall,
  output logic [1:0]    Alu_rs_trans,
  output logic [1:0]    Alu_rt_trans
);

  localparam logic [1:0] SelRf    = 2'b00;
  localparam logic [1:0] SelM     = 2'b01;
  localparam logic [1:0] SelW     = 2'b10;
  localparam logic [1:0] TuseNone = 2'd3;

  // Stage entries
  logic [AW-1:0] r_e_rs, r_e_rt, r_e_dst;
  logic [1:0]    r_e_tnew;
  logic [AW-1:0] r_m_dst;
  logic [1:0]    r_m_tnew;
  // A W result is always forwardable, so W keeps only its destination.
  logic [AW-1:0] r_w_dst;

  logic [1:0] w_e_tnew_dec;
  logic       w_rs_haz, w_rt_haz, w_md_stall;

  function automatic logic src_hazard(
    input logic [AW-1:0] src,
    input logic [1:0]    tuse,
    input logic [AW-1:0] e_dst,
    input logic [1:0]    e_tnew,
    input logic [AW-1:0] m_dst,
    input logic [1:0]    m_tnew
  );
    logic haz;
    haz = 1'b0;
    if (tuse != TuseNone && src != '0) begin
      haz = (e_dst == src && e_tnew > tuse) || (m_dst == src && m_tnew > tuse);
    end
    return haz;
  endfunction

  // M wins over W because it holds the younger write.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic [AW-1:0] m_dst,
    input logic [1:0]    m_tnew,
    input logic [AW-1:0] w_dst
  );
    logic [1:0] sel;
    sel = SelRf;
    if (src != '0) begin
      if (m_dst == src && m_tnew == 2'd0) begin
        sel = SelM;
      end else if (w_dst == src) begin
        sel = SelW;
      end
    end
    return sel;
  endfunction

  assign w_e_tnew_dec = (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;

`ifdef HAZARD_MDU_EN
  assign w_md_stall = D_is_md & (md_start | md_busy);
`else
  assign w_md_stall = 1'b0;
`endif

  always_comb begin
    w_rs_haz = src_hazard(D_rs, D_tuse_rs, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew);
    w_rt_haz = src_hazard(D_rt, D_tuse_rt, r_e_dst, r_e_tnew, r_m_dst, r_m_tnew);
    stall    = w_rs_haz | w_rt_haz | w_md_stall;
  end

  always_comb begin
    Alu_rs_trans = fwd_sel(r_e_rs, r_m_dst, r_m_tnew, r_w_dst);
    Alu_rt_trans = fwd_sel(r_e_rt, r_m_dst, r_m_tnew, r_w_dst);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_rs   <= '0;
      r_e_rt   <= '0;
      r_e_dst  <= '0;
      r_e_tnew <= '0;
      r_m_dst  <= '0;
      r_m_tnew <= '0;
      r_w_dst  <= '0;
    end else begin
      r_w_dst  <= r_m_dst;
      r_m_dst  <= r_e_dst;
      r_m_tnew <= w_e_tnew_dec;
      if (stall || E_clr) begin
        r_e_rs   <= '0;
        r_e_rt   <= '0;
        r_e_dst  <= '0;
        r_e_tnew <= '0;
      end else begin
        r_e_rs   <= D_rs;
        r_e_rt   <= D_rt;
        r_e_dst  <= D_dst;
        r_e_tnew <= D_tnew;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random traffic against an
// age-indexed reference model of the in-flight instructions.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] D_rs, D_rt, D_dst;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
  logic       E_clr;
  logic       stall;
  logic [1:0] Alu_rs_trans, Alu_rt_trans;
`ifdef HAZARD_MDU_EN
  logic       D_is_md, md_start, md_busy;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .D_rs         (D_rs),
    .D_rt         (D_rt),
    .D_tuse_rs    (D_tuse_rs),
    .D_tuse_rt    (D_tuse_rt),
    .D_dst        (D_dst),
    .D_tnew       (D_tnew),
    .E_clr        (E_clr),
`ifdef HAZARD_MDU_EN
    .D_is_md      (D_is_md),
    .md_start     (md_start),
    .md_busy      (md_busy),
`endif
    .stall        (stall),
    .Alu_rs_trans (Alu_rs_trans),
    .Alu_rt_trans (Alu_rt_trans)
  );

  // pipe[k] is the instruction that entered E k cycles ago (0 = E, 1 = M, 2 = W).
  typedef struct {
    int rs;
    int rt;
    int dst;
    int tnew;
    int tuse_rs;
    int tuse_rt;
  } ent_t;

  ent_t pipe[3];
  int   total = 0;
  int   bad   = 0;

  function automatic ent_t bubble();
    ent_t e;
    e = '{rs: 0, rt: 0, dst: 0, tnew: 0, tuse_rs: 3, tuse_rt: 3};
    return e;
  endfunction

  function automatic int rem(int k);
    return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
  endfunction

  function automatic logic src_stall(int s, int tuse);
    logic r;
    r = 1'b0;
    if (tuse != 3 && s != 0) begin
      for (int k = 0; k < 2; k++) begin
        if (pipe[k].dst == s && rem(k) > tuse) r = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic m_stall();
    logic r;
    r = src_stall(int'(D_rs), int'(D_tuse_rs)) | src_stall(int'(D_rt), int'(D_tuse_rt));
`ifdef HAZARD_MDU_EN
    if (D_is_md && (md_start || md_busy)) r = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [1:0] m_sel(int src);
    if (src == 0) return 2'b00;
    if (pipe[1].dst == src && rem(1) == 0) return 2'b01;
    if (pipe[2].dst == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 3; k++) pipe[k] = bubble();
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    if ((pipe[0].tuse_rs <= 1 && pipe[0].rs != 0 && pipe[1].dst == pipe[0].rs && rem(1) > 0) ||
        (pipe[0].tuse_rt <= 1 && pipe[0].rt != 0 && pipe[1].dst == pipe[0].rt && rem(1) > 0)) begin
      bad++;
      $error("FAIL protocol observed=unforwardable_M_match expected=none");
    end
    chk("model_stall", {1'b0, stall}, {1'b0, m_stall()});
    chk("model_rs_sel", Alu_rs_trans, m_sel(pipe[0].rs));
    chk("model_rt_sel", Alu_rt_trans, m_sel(pipe[0].rt));
  endtask

  task automatic advance();
    logic st;
    ent_t nxt;
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      st  = m_stall();
      nxt = '{rs: int'(D_rs), rt: int'(D_rt), dst: int'(D_dst), tnew: int'(D_tnew),
              tuse_rs: int'(D_tuse_rs), tuse_rt: int'(D_tuse_rt)};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (st || E_clr) ? bubble() : nxt;
    end
    #1;
  endtask

  task automatic drive(input int rs, input int rt, input int trs, input int trt,
                       input int dst, input int tnew);
    D_rs      = 5'(rs);
    D_rt      = 5'(rt);
    D_tuse_rs = 2'(trs);
    D_tuse_rt = 2'(trt);
    D_dst     = 5'(dst);
    D_tnew    = 2'(tnew);
  endtask

  task automatic settle();
    @(negedge clk);
    check_model();
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic flush();
    drive(0, 0, 3, 3, 0, 0);
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    E_clr = 1'b0;
`ifdef HAZARD_MDU_EN
    D_is_md = 1'b0; md_start = 1'b0; md_busy = 1'b0;
`endif
    clear_model();
    drive(0, 0, 3, 3, 0, 0);

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2));
      settle();
      chk("rst_stall", {1'b0, stall}, 2'd0);
      chk("rst_rs_sel", Alu_rs_trans, 2'b00);
      chk("rst_rt_sel", Alu_rt_trans, 2'b00);
      advance();
    end
    rst_n = 1'b1;
    drive(3, 0, 1, 3, 0, 0);
    step();
    drive(0, 0, 3, 3, 0, 0);
    settle();
    chk("no_producer_rs_sel", Alu_rs_trans, 2'b00);
    advance();
    flush();

    // ALU -> ALU back to back
    drive(0, 0, 3, 3, 5, 1);
    step();
    drive(5, 0, 1, 3, 6, 1);
    settle();
    chk("alu_alu_stall", {1'b0, stall}, 2'd0);
    advance();
    drive(0, 0, 3, 3, 0, 0);
    settle();
    chk("alu_alu_rs_sel", Alu_rs_trans, 2'b01);
    advance();
    flush();

    // Load-use
    drive(0, 0, 3, 3, 8, 2);
    step();
    drive(0, 8, 3, 1, 10, 1);
    settle();
    chk("ld_use_stall1", {1'b0, stall}, 2'd1);
    advance();
    settle();
    chk("ld_use_stall2", {1'b0, stall}, 2'd0);
    advance();
    drive(0, 0, 3, 3, 0, 0);
    settle();
    chk("ld_use_rt_sel", Alu_rt_trans, 2'b10);
    advance();
    flush();

    // Branch behind ALU op, then behind load
    drive(0, 0, 3, 3, 9, 1);
    step();
    drive(9, 0, 0, 3, 0, 0);
    settle();
    chk("br_alu_stall1", {1'b0, stall}, 2'd1);
    advance();
    settle();
    chk("br_alu_stall2", {1'b0, stall}, 2'd0);
    advance();
    flush();
    drive(0, 0, 3, 3, 9, 2);
    step();
    drive(9, 0, 0, 3, 0, 0);
    settle();
    chk("br_ld_stall1", {1'b0, stall}, 2'd1);
    advance();
    settle();
    chk("br_ld_stall2", {1'b0, stall}, 2'd1);
    advance();
    settle();
    chk("br_ld_stall3", {1'b0, stall}, 2'd0);
    advance();
    flush();

    // Register 0 never hazards; flushed producer never forwards
    drive(0, 0, 3, 3, 0, 2);
    step();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("zero_stall", {1'b0, stall}, 2'd0);
    advance();
    drive(0, 0, 3, 3, 0, 0);
    settle();
    chk("zero_rs_sel", Alu_rs_trans, 2'b00);
    chk("zero_rt_sel", Alu_rt_trans, 2'b00);
    advance();
    flush();
    drive(0, 0, 3, 3, 7, 1);
    E_clr = 1'b1;
    step();
    E_clr = 1'b0;
    drive(7, 0, 1, 3, 0, 0);
    settle();
    chk("clr_stall", {1'b0, stall}, 2'd0);
    advance();
    drive(0, 0, 3, 3, 0, 0);
    settle();
    chk("clr_rs_sel", Alu_rs_trans, 2'b00);
    advance();
    flush();

`ifdef HAZARD_MDU_EN
    D_is_md = 1'b1;
    md_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("md_busy_stall", {1'b0, stall}, 2'd1);
      advance();
    end
    md_busy = 1'b0;
    settle();
    chk("md_idle_stall", {1'b0, stall}, 2'd0);
    advance();
    D_is_md = 1'b0;
    flush();
`endif

    // Random traffic with occasional flush and mid-operation reset
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 2));
      E_clr = ($urandom_range(0, 7) == 0);
`ifdef HAZARD_MDU_EN
      D_is_md  = ($urandom_range(0, 3) == 0);
      md_start = ($urandom_range(0, 3) == 0);
      md_busy  = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        clear_model();
        settle();
        chk("midrst_stall", {1'b0, stall}, 2'd0);
        advance();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
